// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse/level converter family: state encoding and
// a width helper for down-counters sized from a maximum value.
package pulse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Bits needed to hold 0..max_value; never narrower than one bit.
    function automatic int width_for(input int unsigned max_value);
        return (max_value < 2) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up/down counter that saturates at 0 and MAX; simultaneous inc and dec cancel.
// at_max lets the owner detect that an increment would be lost.
module sat_counter
    import pulse_pkg::*;
#(
    parameter int MAX = 3,
    parameter int W   = width_for(MAX)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         at_max
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    always_comb at_max = (count == MAX_V);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && !dec && (count != MAX_V)) begin
            count <= count + 1'b1;
        end else if (dec && !inc && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/pulse_to_level.sv
// Turns single-cycle event pulses into fixed-width level windows, queueing
// pulses that arrive while a window (or its trailing gap) is still running.
module pulse_to_level
    import pulse_pkg::*;
#(
    parameter int HIGH_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int MAX_PENDING = 3,
    parameter int PEND_W      = $clog2(MAX_PENDING + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in,
    input  logic              clear_overflow,
    output logic              level,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int CNT_MAX = ((HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES) - 1;
    localparam int CNT_W   = width_for(CNT_MAX);
    localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             gap_done;
    logic             replay;
    logic             direct;
    logic             q_inc;
    logic             q_dec;
    logic             at_max;
    logic             drop;

    // A pulse landing exactly on the gap exit with nothing queued starts the
    // next window straight away instead of passing through the queue.
    always_comb begin
        gap_done = (state == GAP) && (cnt == '0);
        replay   = gap_done && (pending != '0);
        direct   = gap_done && (pending == '0) && in;
        q_inc    = in && (state != IDLE) && !direct;
        q_dec    = replay;
        drop     = q_inc && !q_dec && at_max;
    end

    sat_counter #(
        .MAX (MAX_PENDING),
        .W   (PEND_W)
    ) u_pending (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (q_inc),
        .dec    (q_dec),
        .count  (pending),
        .at_max (at_max)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in) begin
                        state <= HIGH;
                        cnt   <= HIGH_LOAD;
                        level <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                HIGH: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= GAP;
                        cnt   <= GAP_LOAD;
                        level <= 1'b0;
                    end
                end
                GAP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (replay || direct) begin
                        state <= HIGH;
                        cnt   <= HIGH_LOAD;
                        level <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    level <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Setting wins over clearing so a drop in the clear cycle is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pulse_to_level.sv
// Bench for pulse_to_level: directed windows with literal expectations, then
// random pulse trains compared every cycle against a window-position model.
module tb_pulse_to_level;

    localparam int HC = 4;
    localparam int GC = 2;
    localparam int MP = 3;

    logic       clk;
    logic       rst_n = 1'b1;
    logic       in = 1'b0;
    logic       clear_overflow = 1'b0;
    logic       level;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    // Model: position inside the current window (0..HC+GC-1), -1 when idle.
    int m_pos  = -1;
    int m_pend = 0;
    bit m_ovf  = 1'b0;
    bit m_drop;
    logic m_level;
    logic m_busy;

    assign m_level = (m_pos >= 0) && (m_pos < HC);
    assign m_busy  = (m_pos >= 0);

    pulse_to_level #(
        .HIGH_CYCLES (HC),
        .GAP_CYCLES  (GC),
        .MAX_PENDING (MP)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in             (in),
        .clear_overflow (clear_overflow),
        .level          (level),
        .busy           (busy),
        .pending        (pending),
        .overflow       (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_pos  = -1;
                m_pend = 0;
                m_ovf  = 1'b0;
            end else begin
                m_drop = 1'b0;
                if (m_pos < 0) begin
                    if (in) m_pos = 0;
                end else if (m_pos < HC + GC - 1) begin
                    m_pos++;
                    if (in) begin
                        if (m_pend < MP) m_pend++;
                        else m_drop = 1'b1;
                    end
                end else if (m_pend > 0) begin
                    m_pos = 0;
                    m_pend--;
                    if (in) m_pend++;
                end else if (in) begin
                    m_pos = 0;
                end else begin
                    m_pos = -1;
                end
                if (m_drop) m_ovf = 1'b1;
                else if (clear_overflow) m_ovf = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            checks += 4;
            if (level !== m_level) begin
                failures++;
                $display("[TB] FAIL cycle level t=%0t: got %0b expected %0b", $time, level, m_level);
            end
            if (busy !== m_busy) begin
                failures++;
                $display("[TB] FAIL cycle busy t=%0t: got %0b expected %0b", $time, busy, m_busy);
            end
            if (pending !== 2'(m_pend)) begin
                failures++;
                $display("[TB] FAIL cycle pending t=%0t: got %0d expected %0d", $time, pending, m_pend);
            end
            if (overflow !== m_ovf) begin
                failures++;
                $display("[TB] FAIL cycle overflow t=%0t: got %0b expected %0b", $time, overflow, m_ovf);
            end
        end
    end

    // Drive inputs for the current cycle and advance to the next cycle's sample point.
    task automatic applyStimulus(input logic in_v, input logic clr_v);
        in = in_v;
        clear_overflow = clr_v;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
    endtask

    task automatic checkOutput(input string name, input logic el, input logic eb,
                               input int ep, input logic eo);
        logic [4:0] exp_v;
        logic [4:0] dut_v;
        logic [4:0] mdl_v;
        exp_v = {el, eb, 2'(ep), eo};
        dut_v = {level, busy, pending, overflow};
        mdl_v = {m_level, m_busy, 2'(m_pend), m_ovf};
        checks += 2;
        if (dut_v !== exp_v) begin
            failures++;
            $display("[TB] FAIL %s dut {level,busy,pending,ovf}: got %b expected %b", name, dut_v, exp_v);
        end
        if (mdl_v !== exp_v) begin
            failures++;
            $display("[TB] FAIL %s model {level,busy,pending,ovf}: got %b expected %b", name, mdl_v, exp_v);
        end
    endtask

    initial begin
        int density;

        #1 rst_n = 1'b0;
        #1 checkOutput("reset", 1'b0, 1'b0, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        $display("[TB] single pulse");
        applyStimulus(1'b1, 1'b0);
        checkOutput("single c1", 1'b1, 1'b1, 0, 1'b0);
        idle(3);
        checkOutput("single c4", 1'b1, 1'b1, 0, 1'b0);
        idle(1);
        checkOutput("single c5", 1'b0, 1'b1, 0, 1'b0);
        idle(2);
        checkOutput("single c7", 1'b0, 1'b0, 0, 1'b0);

        $display("[TB] two pulses");
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("two c3", 1'b1, 1'b1, 1, 1'b0);
        idle(3);
        checkOutput("two c6", 1'b0, 1'b1, 1, 1'b0);
        idle(1);
        checkOutput("two c7", 1'b1, 1'b1, 0, 1'b0);
        idle(3);
        checkOutput("two c10", 1'b1, 1'b1, 0, 1'b0);
        idle(2);
        checkOutput("two c12", 1'b0, 1'b1, 0, 1'b0);
        idle(1);
        checkOutput("two c13", 1'b0, 1'b0, 0, 1'b0);

        $display("[TB] burst overflow");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("burst c4", 1'b1, 1'b1, 3, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("burst c5", 1'b0, 1'b1, 3, 1'b1);
        idle(2);
        checkOutput("burst c7", 1'b1, 1'b1, 2, 1'b1);
        idle(13);
        checkOutput("burst c20", 1'b1, 1'b1, 0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("burst c21", 1'b1, 1'b1, 0, 1'b0);
        idle(4);
        checkOutput("burst c25", 1'b0, 1'b0, 0, 1'b0);

        $display("[TB] pulse on gap exit, empty queue");
        applyStimulus(1'b1, 1'b0);
        idle(5);
        applyStimulus(1'b1, 1'b0);
        checkOutput("direct c7", 1'b1, 1'b1, 0, 1'b0);
        idle(3);
        checkOutput("direct c10", 1'b1, 1'b1, 0, 1'b0);
        idle(3);
        checkOutput("direct c13", 1'b0, 1'b0, 0, 1'b0);

        $display("[TB] pulse on gap exit, one queued");
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        idle(3);
        applyStimulus(1'b1, 1'b0);
        checkOutput("replay c7", 1'b1, 1'b1, 1, 1'b0);
        idle(6);
        checkOutput("replay c13", 1'b1, 1'b1, 0, 1'b0);
        idle(6);
        checkOutput("replay c19", 1'b0, 1'b0, 0, 1'b0);

        $display("[TB] async reset mid-window");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);
        idle(3);
        checkOutput("prereset c8", 1'b1, 1'b1, 2, 1'b1);
        #2 rst_n = 1'b0;
        #1 checkOutput("async reset", 1'b0, 1'b0, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        checkOutput("post reset idle", 1'b0, 1'b0, 0, 1'b0);

        $display("[TB] random pulse trains");
        density = 30;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) density = $urandom_range(5, 90);
            if ($urandom_range(0, 399) == 0) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            applyStimulus(($urandom_range(0, 99) < density) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
        end
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
